// File: rtl/multi_wavegen.sv
// Multi-channel wavetable generator: each tick reads one sample per channel and outputs their average.
// Define MULTI_WAVEGEN_GAIN_EN for per-channel Q0.8 gain, which adds one pipeline cycle.
module multi_wavegen #(
    parameter int NUM_CH       = 4,
    parameter int SAMPLE_WIDTH = 16,
    parameter int ADDR_WIDTH   = 8,
    parameter int DIVIDER_LOG2 = 4,
    localparam int CH_BITS     = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_enable,
    input  logic [CH_BITS-1:0]      wr_ch,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [SAMPLE_WIDTH-1:0] wr_data,
    input  logic                    cfg_enable,
    input  logic [CH_BITS-1:0]      cfg_ch,
    input  logic [ADDR_WIDTH-1:0]   cfg_step,
    input  logic [ADDR_WIDTH-1:0]   cfg_range,
    input  logic [7:0]              cfg_gain,
    input  logic [NUM_CH-1:0]       ch_enable,
    output logic [SAMPLE_WIDTH-1:0] mix_out,
    output logic                    mix_valid
);
    localparam int ACC_WIDTH = SAMPLE_WIDTH + CH_BITS;
    localparam int TAB_DEPTH = NUM_CH << ADDR_WIDTH;
`ifdef MULTI_WAVEGEN_GAIN_EN
    localparam int DRAIN_LEN = 2;
`else
    localparam int DRAIN_LEN = 1;
`endif

    typedef enum logic [1:0] {IDLE, READ, DRAIN, OUT} state_t;
    state_t state, state_nxt;

    logic [DIVIDER_LOG2-1:0] presc;
    logic                    tick;
    logic [CH_BITS-1:0]      ch;
    logic                    last_ch;
    logic                    drain_cnt;
    logic                    drain_last;

    logic [ADDR_WIDTH-1:0] step_r  [NUM_CH];
    logic [ADDR_WIDTH-1:0] range_r [NUM_CH];
    logic [ADDR_WIDTH-1:0] phase_r [NUM_CH];
    logic [ADDR_WIDTH-1:0] cur_rng;
    logic [ADDR_WIDTH-1:0] cur_phase;
    logic [ADDR_WIDTH-1:0] phase_nxt;
    logic [ADDR_WIDTH:0]   sum;
    logic [ADDR_WIDTH:0]   wrapped;

    logic [SAMPLE_WIDTH-1:0] tab [TAB_DEPTH];
    logic [SAMPLE_WIDTH-1:0] rd_dat;
    logic                    rd_use;
    logic                    add_use;
    logic [SAMPLE_WIDTH-1:0] add_dat;
    logic [ACC_WIDTH-1:0]    acc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) presc <= '0;
        else       presc <= presc + 1'b1;
    end
    assign tick = &presc;

    assign last_ch    = (ch == CH_BITS'(NUM_CH - 1));
    assign drain_last = (DRAIN_LEN == 1) || drain_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (tick) state_nxt = READ;
            READ:    if (last_ch) state_nxt = DRAIN;
            DRAIN:   if (drain_last) state_nxt = OUT;
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) drain_cnt <= 1'b0;
        else       drain_cnt <= (state == DRAIN) && !drain_last;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                step_r[i]  <= '0;
                range_r[i] <= '1;
            end
        end else if (cfg_enable) begin
            step_r[cfg_ch]  <= cfg_step;
            range_r[cfg_ch] <= cfg_range;
        end
    end

    // A phase left beyond a freshly shrunk range restarts from address 0.
    assign cur_rng   = range_r[ch];
    assign cur_phase = (phase_r[ch] > cur_rng) ? '0 : phase_r[ch];
    assign sum       = {1'b0, cur_phase} + {1'b0, step_r[ch]};
    assign wrapped   = (sum > {1'b0, cur_rng}) ? (sum - {1'b0, cur_rng} - 1'b1) : sum;
    assign phase_nxt = (wrapped > {1'b0, cur_rng}) ? '0 : wrapped[ADDR_WIDTH-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) phase_r[i] <= '0;
        end else if (state == READ && ch_enable[ch]) begin
            phase_r[ch] <= phase_nxt;
        end
    end

    // Table RAM is never reset; a same-word read/write returns the old data.
    always_ff @(posedge clk) begin
        if (wr_enable) tab[{wr_ch, wr_addr}] <= wr_data;
        if (state == READ) rd_dat <= tab[{ch, cur_phase}];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rd_use <= 1'b0;
        else       rd_use <= (state == READ) && ch_enable[ch];
    end

`ifdef MULTI_WAVEGEN_GAIN_EN
    logic [7:0]                gain_r [NUM_CH];
    logic [7:0]                rd_gain;
    logic [SAMPLE_WIDTH+7:0]   prod;
    logic                      sc_use;
    logic [SAMPLE_WIDTH-1:0]   sc_dat;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) gain_r[i] <= 8'hFF;
        end else if (cfg_enable) begin
            gain_r[cfg_ch] <= cfg_gain;
        end
    end

    assign prod = {8'b0, rd_dat} * {{SAMPLE_WIDTH{1'b0}}, rd_gain};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_gain <= '0;
            sc_use  <= 1'b0;
            sc_dat  <= '0;
        end else begin
            rd_gain <= gain_r[ch];
            sc_use  <= rd_use;
            sc_dat  <= prod[SAMPLE_WIDTH+7:8];
        end
    end

    assign add_use = sc_use;
    assign add_dat = sc_dat;
`else
    logic unused_gain;
    assign unused_gain = ^cfg_gain;
    assign add_use     = rd_use;
    assign add_dat     = rd_dat;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc       <= '0;
            ch        <= '0;
            mix_out   <= '0;
            mix_valid <= 1'b0;
        end else begin
            mix_valid <= (state == OUT);
            if (state == OUT) mix_out <= acc[ACC_WIDTH-1:CH_BITS];
            if (state == IDLE && tick) begin
                acc <= '0;
                ch  <= '0;
            end else begin
                if (add_use) acc <= acc + {{CH_BITS{1'b0}}, add_dat};
                if (state == READ) ch <= ch + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_multi_wavegen.sv
// Bench for multi_wavegen (default build): vector tables, hand-written corner sequences, and random
// tables/config checked against a per-tick arithmetic model.
module tb_multi_wavegen;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr_enable = 1'b0;
    logic [1:0]  wr_ch = '0;
    logic [7:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        cfg_enable = 1'b0;
    logic [1:0]  cfg_ch = '0;
    logic [7:0]  cfg_step = '0;
    logic [7:0]  cfg_range = '0;
    logic [7:0]  cfg_gain = '0;
    logic [3:0]  ch_enable = '0;
    logic [15:0] mix_out;
    logic        mix_valid;

    multi_wavegen #(.NUM_CH(4), .SAMPLE_WIDTH(16), .ADDR_WIDTH(8), .DIVIDER_LOG2(4)) dut (
        .clk(clk), .reset(reset), .wr_enable(wr_enable), .wr_ch(wr_ch), .wr_addr(wr_addr),
        .wr_data(wr_data), .cfg_enable(cfg_enable), .cfg_ch(cfg_ch), .cfg_step(cfg_step),
        .cfg_range(cfg_range), .cfg_gain(cfg_gain), .ch_enable(ch_enable),
        .mix_out(mix_out), .mix_valid(mix_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  en;
        logic [15:0] exp;
    } vec_t;

    int checks = 0;
    int failures = 0;
    int mdl_tab [4][256];
    int m_step [4];
    int m_rng [4];
    int m_ph [4];
    vec_t wrap_v [6];
    vec_t hold_v [7];
    logic [15:0] val;
    bit ok;
    int expv;

    task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%0h expected=%0h", name, idx, act, exp);
        end
    endtask

    task automatic tick_clk(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ram_wr(int c, int a, int d);
        wr_enable = 1'b1;
        wr_ch = 2'(c);
        wr_addr = 8'(a);
        wr_data = 16'(d);
        mdl_tab[c][a] = d;
        tick_clk(1);
        wr_enable = 1'b0;
    endtask

    task automatic cfg_wr(int c, int s, int r);
        cfg_enable = 1'b1;
        cfg_ch = 2'(c);
        cfg_step = 8'(s);
        cfg_range = 8'(r);
        cfg_gain = 8'($urandom_range(0, 255));
        tick_clk(1);
        cfg_enable = 1'b0;
        m_step[c] = s;
        m_rng[c] = r;
    endtask

    task automatic start_reset();
        ch_enable = '0;
        reset = 1'b1;
        tick_clk(2);
    endtask

    task automatic release_reset();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            m_step[k] = 0;
            m_rng[k] = 255;
            m_ph[k] = 0;
        end
    endtask

    task automatic wait_mix(output logic [15:0] v, output bit seen);
        seen = 1'b0;
        v = '0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick_clk(1);
            if (mix_valid === 1'b1) begin
                seen = 1'b1;
                v = mix_out;
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL wait_mix: no mix_valid within 40 cycles");
        end
    endtask

    task automatic first_mix(string name, logic [15:0] exp_val);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < 40) begin
            tick_clk(1);
            n++;
            if (mix_valid === 1'b1) seen = 1'b1;
        end
        check({name, "_latency"}, 0, n, 22);
        check({name, "_value"}, 0, mix_out, exp_val);
    endtask

    // One mix from the channel rules: average of enabled samples, phases advanced with wrap.
    task automatic model_tick(input logic [3:0] en, output int result);
        int total = 0;
        for (int k = 0; k < 4; k++) begin
            if (en[k]) begin
                int p;
                p = (m_ph[k] > m_rng[k]) ? 0 : m_ph[k];
                total += mdl_tab[k][p];
                p += m_step[k];
                if (p > m_rng[k]) p = p - m_rng[k] - 1;
                if (p > m_rng[k]) p = 0;
                m_ph[k] = p;
            end
        end
        result = total / 4;
    endtask

    initial begin
        wrap_v = '{'{4'b0001, 16'd0}, '{4'b0001, 16'd0}, '{4'b0001, 16'd1},
                   '{4'b0001, 16'd0}, '{4'b0001, 16'd0}, '{4'b0001, 16'd1}};
        hold_v = '{'{4'b0010, 16'd0},  '{4'b0010, 16'd16}, '{4'b0000, 16'd0},
                   '{4'b0000, 16'd0},  '{4'b0000, 16'd0},  '{4'b0010, 16'd32},
                   '{4'b0010, 16'd48}};

        // Reset held: outputs quiet; constant tables loaded meanwhile.
        #1 reset = 1'b1;
        for (int c = 0; c < 4; c++) ram_wr(c, 0, (c + 1) << 12);
        for (int i = 0; i < 3; i++) begin
            tick_clk(1);
            check("rst_mix_out", i, mix_out, 0);
            check("rst_mix_valid", i, mix_valid, 0);
        end
        release_reset();
        ch_enable = 4'hF;
        first_mix("first", 16'h2800);

        for (int i = 0; i < 3; i++) begin
            wait_mix(val, ok);
            if (ok) check("const_mix", i, val, 16'h2800);
        end
        tick_clk(1);
        check("valid_pulse", 0, mix_valid, 0);

        // Reset during READ: outputs clear at once, aborted mix never appears, RAM survives.
        tick_clk(10);
        check("held_mix_out", 0, mix_out, 16'h2800);
        reset = 1'b1;
        #1;
        check("midrst_mix_out", 0, mix_out, 0);
        check("midrst_mix_valid", 0, mix_valid, 0);
        tick_clk(2);
        release_reset();
        first_mix("after_rst", 16'h2800);

        // Phase wrap on ch0: range 5, step 2.
        start_reset();
        for (int a = 0; a < 8; a++) ram_wr(0, a, a);
        release_reset();
        cfg_wr(0, 2, 5);
        for (int i = 0; i < 6; i++) begin
            ch_enable = wrap_v[i].en;
            wait_mix(val, ok);
            if (ok) check("wrap", i, val, wrap_v[i].exp);
        end

        // Disable hold on ch1, then a range cut below the current phase.
        start_reset();
        for (int a = 0; a < 8; a++) ram_wr(1, a, a * 64);
        release_reset();
        cfg_wr(1, 1, 255);
        for (int i = 0; i < 7; i++) begin
            ch_enable = hold_v[i].en;
            wait_mix(val, ok);
            if (ok) check("hold", i, val, hold_v[i].exp);
        end
        cfg_wr(1, 1, 2);
        wait_mix(val, ok);
        if (ok) check("range_cut", 0, val, 16'd0);
        wait_mix(val, ok);
        if (ok) check("range_cut", 1, val, 16'd16);

        // Random tables, config, enables and mid-run reconfiguration.
        start_reset();
        for (int c = 0; c < 4; c++)
            for (int a = 0; a < 256; a++) ram_wr(c, a, int'($urandom_range(0, 65535)));
        release_reset();
        for (int c = 0; c < 4; c++)
            cfg_wr(c, int'($urandom_range(0, 40)), int'($urandom_range(0, 1) ? $urandom_range(0, 255) : $urandom_range(0, 15)));
        for (int i = 0; i < 40; i++) begin
            ch_enable = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0)
                cfg_wr(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)), int'($urandom_range(0, 31)));
            model_tick(ch_enable, expv);
            wait_mix(val, ok);
            if (ok) check("random", i, val, expv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
